// File: rtl/rs_hs_pp_tail_fifo.sv
// rs_hs_pp_tail_fifo
//   Tail-stage FIFO of a handshake relay-station pipeline. It sits right after
//   the tail gate and drives the consumer side. The upstream stages see
//   if_full_n only after several register stages, so words keep arriving after
//   full_n drops. GRACE_PERIOD spare entries absorb those in-flight words. Any
//   write that still finds no room is dropped and latched in a sticky overflow
//   flag. The output is first-word-fall-through.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous reset, active low
//   if_write   : upstream valid; pushed whenever storage is available
//   if_din     : write data
//   if_full_n  : registered, 1 while occupancy < DEPTH
//   if_read    : consumer pop request
//   if_dout    : head entry (FWFT), valid while if_empty_n = 1
//   if_empty_n : registered, 1 while occupancy > 0
//   occupancy  : registered entry count
//   overflow   : sticky, set when a write is dropped
module rs_hs_pp_tail_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 24,
  parameter int GRACE_PERIOD = 4,
  parameter int REAL_DEPTH   = DEPTH + GRACE_PERIOD,
  parameter int ADDR_WIDTH   = $clog2(REAL_DEPTH),
  parameter int CNT_WIDTH    = $clog2(REAL_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0]  REAL_DEPTH_C = CNT_WIDTH'(REAL_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_C      = CNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(REAL_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO     = '0;

  logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [CNT_WIDTH-1:0]  occ_next;

  // Pointer advance with explicit wrap; REAL_DEPTH need not be a power of 2.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // A pop frees the head in the same cycle, so a write into a completely full
  // FIFO is still accepted when the consumer reads.
  always_comb begin
    pop      = if_read & (occupancy != CNT_ZERO);
    push     = if_write & ((occupancy < REAL_DEPTH_C) | pop);
    drop     = if_write & ~push;
    occ_next = occupancy;
    if (push && !pop) occ_next = occupancy + CNT_ONE;
    if (pop && !push) occ_next = occupancy - CNT_ONE;
  end

  // Storage: data path only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= if_din;
  end

  assign if_dout = mem[rd_ptr];

  // Control state. Flags are registered from the next count so they move on
  // the same edge as occupancy and have no path from if_write/if_read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      if_full_n  <= 1'b1;
      if_empty_n <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occupancy  <= occ_next;
      if_full_n  <= (occ_next < DEPTH_C);
      if_empty_n <= (occ_next != CNT_ZERO);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/rs_hs_pp_tail_fifo.md
Name: rs_hs_pp_tail_fifo

Overview:
- Tail-stage FIFO of a handshake relay-station pipeline; sits directly after the tail gate and drives the consumer-facing if_dout/if_empty_n.
- Upstream stages observe if_full_n only after several register stages, so data keeps arriving after full_n deasserts.
- The FIFO reserves GRACE_PERIOD extra entries so no in-flight word is lost, and it flags any write that still overflows the storage.
- Output is first-word-fall-through.

Parameters:
- DATA_WIDTH, 32, payload width.
- DEPTH, 24, nominal capacity; if_full_n deasserts at this occupancy.
- GRACE_PERIOD, 4, extra entries that absorb writes already in flight after full_n drops.
- REAL_DEPTH, DEPTH+GRACE_PERIOD, physical entry count (need not be a power of 2).
- ADDR_WIDTH, $clog2(REAL_DEPTH), pointer width.
- CNT_WIDTH, $clog2(REAL_DEPTH+1), occupancy width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- if_write  in  1  upstream valid; the word is pushed whenever storage is available, independent of if_full_n.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  registered; 1 while occupancy < DEPTH.
- if_read  in  1  consumer pop request.
- if_dout  out  DATA_WIDTH  head entry, FWFT; valid when if_empty_n=1.
- if_empty_n  out  1  registered; 1 while occupancy > 0.
- occupancy  out  CNT_WIDTH  registered entry count.
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, occupancy=0, if_full_n=1, if_empty_n=0, overflow=0. Storage contents are not reset; if_dout is don't-care while empty.
- Reset asserted mid-operation: all stored words are discarded immediately. The first cycle after release behaves as a fresh, empty FIFO.
- Pop rule: pop = if_read & (occupancy != 0). A read while empty is ignored, with no pointer or count change.
- Push rule: push = if_write & ((occupancy < REAL_DEPTH) | pop).
  - A write to a completely full FIFO in the same cycle as a pop is accepted.
- Drop rule: drop = if_write & ~push. The word is discarded and overflow is set to 1 on the next edge. overflow stays 1 until reset.
- Storage: push writes mem[wr_ptr]. Pointers increment and wrap from REAL_DEPTH-1 to 0, with explicit compare, not a power-of-2 mask.
- if_dout = mem[rd_ptr], combinational from the storage array. Data written at edge N is visible on if_dout after edge N when the FIFO was empty. Write-to-output latency is 1 cycle.
- Occupancy update:
  - next = occupancy + push - pop.
  - Simultaneous push and pop leaves it unchanged.
  - Never exceeds REAL_DEPTH and never underflows.
- Flags are registered from next:
  - if_full_n <= (next < DEPTH).
  - if_empty_n <= (next != 0).
  - occupancy <= next.
  - Flags therefore change on the same edge as the count, with no extra lag.
- Occupancy between DEPTH and REAL_DEPTH: if_full_n=0, writes are still accepted. This is the grace region.
- Ordering: strict FIFO order, including across pointer wrap and in the grace region.
- No combinational path from if_write to if_full_n, or from if_read to if_empty_n.

Test Plan:
Bench configuration for all scenarios: DEPTH=4, GRACE_PERIOD=2, REAL_DEPTH=6, DATA_WIDTH=32.
- Reset then idle -> if_full_n=1, if_empty_n=0, occupancy=0, overflow=0. A read pulse while empty leaves all values unchanged.
- Single write 0xA5A5_0001 at edge N -> after N, if_empty_n=1 and if_dout=0xA5A5_0001. Pop at edge N+1 -> if_empty_n=0, occupancy=0.
- Writes 1..4 with no reads -> if_full_n drops after the 4th edge. Writes 5,6 are accepted (occupancy=6, overflow=0). Write 7 is dropped (overflow=1, occupancy=6). Draining returns exactly 1..6.
- At occupancy=6, simultaneous write 0x77 and read -> head is popped, 0x77 stored, occupancy stays 6, overflow stays 0. 0x77 emerges last.
- Streaming 20 words with continuous write and random read (~50%), occupancy held ≤ 4 -> output equals input order across ≥3 pointer wraps, and if_full_n is consistent with occupancy every cycle.
- reset pulsed low at occupancy=3, asynchronously mid-cycle -> outputs reset immediately, without waiting for a clk edge. After release, a write of 0x1234 produces if_dout=0x1234 with occupancy=1.
